// File: rtl/svi_rr_arbiter_if.sv
// Requester-side link for svi_rr_arbiter: x = request, y = grant, z = release.
// Only the arbiter drives y; the requester drives x and z.
interface I;
    logic x;
    logic y;
    logic z;

    modport arb (input x, input z, output y);
    modport req (output x, output z, input y);
endinterface

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter with one-hot grants, bounded grant tenure and a saturating
// count of grants issued. One idle cycle always separates consecutive grants.
module svi_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    I.arb                            u_I [N_REQ-1:0],
    output logic                     o_gnt_vld,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
    output logic                     o_timeout,
    output logic [CNT_W-1:0]         o_grant_count
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               vld_q, vld_d;
    logic [N_REQ-1:0]   y_q, y_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   req_s;
    logic [N_REQ-1:0]   rel_s;
    logic               win_found_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      cand_s;
    logic               cur_x_s;
    logic               cur_z_s;
    logic               limit_s;
    logic               release_s;

    for (genvar g = 0; g < N_REQ; g++) begin : g_io
        assign req_s[g]  = u_I[g].x;
        assign rel_s[g]  = u_I[g].z;
        assign u_I[g].y  = y_q[g];
    end

    // First active request at or after ptr, wrapping around the requester array.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand_s = IW'((int'(ptr_q) + off) % N_REQ);
            if (!win_found_s && req_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign cur_x_s   = req_s[idx_q];
    assign cur_z_s   = rel_s[idx_q];
    assign limit_s   = (hold_q == HW'(MAX_HOLD - 1));
    assign release_s = cur_z_s | ~cur_x_s | limit_s;

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        y_d     = y_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_GRANT;
                    y_d     = '0;
                    y_d[win_idx_s] = 1'b1;
                    vld_d   = 1'b1;
                    idx_d   = win_idx_s;
                    hold_d  = '0;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    state_d = ST_IDLE;
                    y_d     = '0;
                    vld_d   = 1'b0;
                    idx_d   = '0;
                    hold_d  = '0;
                    ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
                    // A timeout only when the limit alone ended the grant.
                    tmo_d   = limit_s & cur_x_s & ~cur_z_s;
                end else begin
                    hold_d  = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                y_d     = '0;
                vld_d   = 1'b0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            y_q     <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            y_q     <= y_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_gnt_vld     = vld_q;
    assign o_gnt_idx     = idx_q;
    assign o_timeout     = tmo_q;
    assign o_grant_count = cnt_q;

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Directed bench for svi_rr_arbiter: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_svi_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  req_a, rel_a, y_a;
    logic [7:0]  req_b, rel_b, y_b;
    logic        vld_a, tmo_a, vld_b, tmo_b;
    logic [2:0]  idx_a, idx_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_chk;
    int n_pass;

    I bus_a [7:0] ();
    I bus_b [7:0] ();

    for (genvar g = 0; g < 8; g++) begin : g_bus
        assign bus_a[g].x = req_a[g];
        assign bus_a[g].z = rel_a[g];
        assign y_a[g]     = bus_a[g].y;
        assign bus_b[g].x = req_b[g];
        assign bus_b[g].z = rel_b[g];
        assign y_b[g]     = bus_b[g].y;
    end

    svi_rr_arbiter #(.N_REQ(8), .MAX_HOLD(4), .CNT_W(16)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .u_I           (bus_a),
        .o_gnt_vld     (vld_a),
        .o_gnt_idx     (idx_a),
        .o_timeout     (tmo_a),
        .o_grant_count (cnt_a)
    );

    svi_rr_arbiter #(.N_REQ(8), .MAX_HOLD(4), .CNT_W(2)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .u_I           (bus_b),
        .o_gnt_vld     (vld_b),
        .o_gnt_idx     (idx_b),
        .o_timeout     (tmo_b),
        .o_grant_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        req_a  = 8'h00;
        rel_a  = 8'h00;
        req_b  = 8'h00;
        rel_b  = 8'h00;
        rst    = 1'b1;

        // 1. reset state
        step();
        step();
        rst = 1'b0;
        check_val("rst_y",   32'(y_a),   32'h0);
        check_val("rst_vld", 32'(vld_a), 32'h0);
        check_val("rst_idx", 32'(idx_a), 32'h0);
        check_val("rst_cnt", 32'(cnt_a), 32'h0);
        check_val("rst_tmo", 32'(tmo_a), 32'h0);

        // 2. single requester 3 with release in its second grant cycle
        req_a = 8'h08;
        step();
        check_val("t2_y1",   32'(y_a),   32'h08);
        check_val("t2_idx",  32'(idx_a), 32'd3);
        check_val("t2_vld",  32'(vld_a), 32'h1);
        step();
        check_val("t2_y2",   32'(y_a),   32'h08);
        rel_a = 8'h08;
        step();
        req_a = 8'h00;
        rel_a = 8'h00;
        check_val("t2_ylow", 32'(y_a),   32'h0);
        check_val("t2_vld0", 32'(vld_a), 32'h0);
        check_val("t2_tmo",  32'(tmo_a), 32'h0);
        check_val("t2_cnt",  32'(cnt_a), 32'd1);

        // 3. all requesting, every grant released in its first cycle
        do_reset();
        req_a = 8'hFF;
        rel_a = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check_val($sformatf("t3_y%0d", k),   32'(y_a),   32'(8'h01 << (k % 8)));
            check_val($sformatf("t3_idx%0d", k), 32'(idx_a), 32'(k % 8));
            step();
            check_val($sformatf("t3_gap%0d", k), 32'(vld_a), 32'h0);
        end
        check_val("t3_cnt", 32'(cnt_a), 32'd9);
        req_a = 8'h00;
        rel_a = 8'h00;

        // 4. requester 5 held with no release -> 4-cycle tenure then timeout
        req_a = 8'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("t4_hold%0d", k), 32'(y_a),   32'h20);
            check_val($sformatf("t4_tmo%0d", k),  32'(tmo_a), 32'h0);
        end
        step();
        check_val("t4_ylow", 32'(y_a),   32'h0);
        check_val("t4_tmo",  32'(tmo_a), 32'h1);
        step();
        check_val("t4_regrant", 32'(y_a),   32'h20);
        check_val("t4_tmo_off", 32'(tmo_a), 32'h0);

        // 5. requester 2 arrives mid-grant; ignored until requester 5 times out
        req_a = 8'h24;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("t5_hold%0d", k), 32'(y_a), 32'h20);
        end
        step();
        check_val("t5_tmo", 32'(tmo_a), 32'h1);
        step();
        check_val("t5_y2",   32'(y_a),   32'h04);
        check_val("t5_idx2", 32'(idx_a), 32'd2);
        req_a = 8'h00;
        rel_a = 8'h04;
        step();
        rel_a = 8'h00;
        check_val("t5_rel", 32'(y_a), 32'h0);

        // 6. reset while requester 4 holds the grant
        req_a = 8'h10;
        step();
        check_val("t6_y4", 32'(y_a), 32'h10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_y0",   32'(y_a),   32'h0);
        check_val("t6_vld",  32'(vld_a), 32'h0);
        check_val("t6_tmo",  32'(tmo_a), 32'h0);
        check_val("t6_cnt",  32'(cnt_a), 32'h0);
        req_a = 8'hFF;
        step();
        check_val("t6_next", 32'(y_a),   32'h01);
        check_val("t6_idx",  32'(idx_a), 32'd0);
        req_a = 8'h00;

        // 7. 2-bit counter saturates after three grants
        req_b = 8'h01;
        rel_b = 8'h01;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val($sformatf("t7_y%0d", k),   32'(y_b),   32'h01);
            check_val($sformatf("t7_cnt%0d", k), 32'(cnt_b), (k < 3) ? 32'(k + 1) : 32'd3);
            step();
        end
        req_b = 8'h00;
        rel_b = 8'h00;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
